// File: rtl/comp_split_pkg.sv
// comp_split_pkg: shared FSM state encoding and beat-order constants for the split datapath
package comp_split_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2
    } state_e;

    localparam bit LSB_FIRST = 1'b0;
    localparam bit MSB_FIRST = 1'b1;

    // True when the half selected for the given beat is the upper half of the wide word
    function automatic logic sel_high(input logic second_beat, input bit msb_first);
        return second_beat ^ (msb_first == MSB_FIRST);
    endfunction

endpackage

// File: rtl/comp_split_hold.sv
// comp_split_hold: holding register for the A/B wide pair plus the half-select mux feeding the narrow beat
module comp_split_hold
    import comp_split_pkg::*;
#(
    parameter int p_size      = 1,
    parameter bit P_MSB_FIRST = LSB_FIRST
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  second_i,
    input  logic [2*p_size-1:0]   a_i,
    input  logic [2*p_size-1:0]   b_i,
    output logic [p_size-1:0]     a_o,
    output logic [p_size-1:0]     b_o
);

    logic [2*p_size-1:0] a_q, b_q;
    logic                hi;

    // Capture the pair only on an accepted input transfer so upstream may move on immediately
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else if (load_i) begin
            a_q <= a_i;
            b_q <= b_i;
        end
    end

    // Outside BEAT0 the second half is shown, so IDLE keeps presenting the last emitted beat
    always_comb begin
        hi  = sel_high(second_i, P_MSB_FIRST);
        a_o = hi ? a_q[2*p_size-1:p_size] : a_q[p_size-1:0];
        b_o = hi ? b_q[2*p_size-1:p_size] : b_q[p_size-1:0];
    end

endmodule

// File: rtl/comp_split.sv
// comp_split: splits each accepted 2*p_size-bit A/B pair into two p_size-bit beats with ready/valid on both sides.
// Optional parity feature enabled by defining COMP_SPLIT_PARITY_EN (adds i_par / o_par).
module comp_split
    import comp_split_pkg::*;
#(
    parameter int p_size      = 1,
    parameter bit P_MSB_FIRST = LSB_FIRST,
    parameter int P_CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2*p_size-1:0]   i_param,
    input  logic [2*p_size-1:0]   i_param_2,
    input  logic                  dv,
    output logic                  i_ready,
    output logic [p_size-1:0]     o_param,
    output logic [p_size-1:0]     o_param_2,
    output logic                  ena,
    output logic                  o_last,
    input  logic                  o_ready,
    output logic [P_CNT_W-1:0]    o_count
`ifdef COMP_SPLIT_PARITY_EN
    ,
    input  logic                  i_par,
    output logic                  o_par
`endif
);

    state_e               state_q, state_d;
    logic                 in_x, out_x, second;
    logic [P_CNT_W-1:0]   cnt_q, cnt_d;

    // State register
    always_ff @(posedge clk) begin
        state_q <= rst ? ST_IDLE : state_d;
    end

    // Next state; BEAT1 can reload straight into BEAT0 to keep one pair per two cycles
    always_comb begin
        state_d = state_q == ST_IDLE  ? (in_x ? ST_BEAT0 : ST_IDLE) :
                  state_q == ST_BEAT0 ? (out_x ? ST_BEAT1 : ST_BEAT0) :
                  state_q == ST_BEAT1 ? (out_x ? (in_x ? ST_BEAT0 : ST_IDLE) : ST_BEAT1) :
                  ST_IDLE;
    end

    // Handshake outputs and transfer qualifiers; i_ready depends only on state and o_ready
    always_comb begin
        ena     = (state_q == ST_BEAT0) | (state_q == ST_BEAT1);
        o_last  = state_q == ST_BEAT1;
        i_ready = (state_q == ST_IDLE) | (o_last & o_ready);
        in_x    = dv & i_ready;
        out_x   = ena & o_ready;
        second  = state_q != ST_BEAT0;
        cnt_d   = cnt_q + P_CNT_W'(out_x & o_last);
    end

    // Completed-pair counter, wraps naturally at its width
    always_ff @(posedge clk) begin
        cnt_q <= rst ? '0 : cnt_d;
    end

    assign o_count = cnt_q;

    comp_split_hold #(
        .p_size      (p_size),
        .P_MSB_FIRST (P_MSB_FIRST)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .load_i   (in_x),
        .second_i (second),
        .a_i      (i_param),
        .b_i      (i_param_2),
        .a_o      (o_param),
        .b_o      (o_param_2)
    );

`ifdef COMP_SPLIT_PARITY_EN
    logic perr_q;

    // Remember whether the pair arrived with bad parity; it flips o_par on both of its beats
    always_ff @(posedge clk) begin
        if (rst)
            perr_q <= 1'b0;
        else if (in_x)
            perr_q <= (^{i_param, i_param_2}) ^ i_par;
    end

    assign o_par = (^{o_param, o_param_2}) ^ perr_q;
`endif

endmodule

// File: tb/tb_comp_split.sv
// tb_comp_split: table vectors, hand sequences and random traffic checked against a beat-queue model
module tb_comp_split;

    logic        clk, rst, dv, o_ready;
    logic [7:0]  ia, ib;
    logic        ir0, ir1, ena0, ena1, last0, last1;
    logic [3:0]  p0, q0, p1, q1;
    logic [15:0] cnt0;
    logic [1:0]  cnt1;
`ifdef COMP_SPLIT_PARITY_EN
    logic        ipar, par0, par1;
`endif

    comp_split #(.p_size(4), .P_MSB_FIRST(1'b0), .P_CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .i_param(ia), .i_param_2(ib), .dv(dv), .i_ready(ir0),
        .o_param(p0), .o_param_2(q0), .ena(ena0), .o_last(last0), .o_ready(o_ready),
        .o_count(cnt0)
`ifdef COMP_SPLIT_PARITY_EN
        , .i_par(ipar), .o_par(par0)
`endif
    );

    comp_split #(.p_size(4), .P_MSB_FIRST(1'b1), .P_CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .i_param(ia), .i_param_2(ib), .dv(dv), .i_ready(ir1),
        .o_param(p1), .o_param_2(q1), .ena(ena1), .o_last(last1), .o_ready(o_ready),
        .o_count(cnt1)
`ifdef COMP_SPLIT_PARITY_EN
        , .i_par(ipar), .o_par(par1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a0, b0, a1, b1;
        logic       last;
        logic       perr;
    } beat_t;

    typedef struct {
        logic        dv;
        logic [7:0]  a, b;
        logic        r;
        logic        ena, ir, last;
        logic [3:0]  p0, q0, p1, q1;
        logic [15:0] cnt;
    } vec_t;

    beat_t       mq[$];
    logic [3:0]  lp0, lq0, lp1, lq1;
    int unsigned pairs;
    logic        cur_bad;
    int          checks = 0;
    int          fails  = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", n, act, exp, $time);
        end
    endtask

    task automatic drive(input logic d, input logic [7:0] a, input logic [7:0] b,
                         input logic r, input logic bad);
        @(negedge clk);
        dv = d; ia = a; ib = b; o_ready = r; cur_bad = bad;
`ifdef COMP_SPLIT_PARITY_EN
        ipar = (^{a, b}) ^ bad;
`endif
        #1;
    endtask

    // Compare every output against the head of the expected beat queue, then advance the model
    task automatic mcheck();
        beat_t f;
        logic  emp, exp_ir, in_x, out_x;
        emp = mq.size() == 0;
        if (emp) f = '{a0: lp0, b0: lq0, a1: lp1, b1: lq1, last: 1'b0, perr: 1'b0};
        else     f = mq[0];
        exp_ir = emp | (f.last & o_ready);
        chk("ena0",  32'(ena0),  32'(!emp));
        chk("ena1",  32'(ena1),  32'(!emp));
        chk("last0", 32'(last0), 32'(f.last));
        chk("last1", 32'(last1), 32'(f.last));
        chk("p0",    32'(p0),    32'(f.a0));
        chk("q0",    32'(q0),    32'(f.b0));
        chk("p1",    32'(p1),    32'(f.a1));
        chk("q1",    32'(q1),    32'(f.b1));
        chk("ir0",   32'(ir0),   32'(exp_ir));
        chk("ir1",   32'(ir1),   32'(exp_ir));
        chk("cnt0",  32'(cnt0),  32'(pairs % 65536));
        chk("cnt1",  32'(cnt1),  32'(pairs % 4));
`ifdef COMP_SPLIT_PARITY_EN
        if (!emp) begin
            chk("par0", 32'(par0), 32'((^{f.a0, f.b0}) ^ f.perr));
            chk("par1", 32'(par1), 32'((^{f.a1, f.b1}) ^ f.perr));
        end
`endif
        in_x  = dv & exp_ir;
        out_x = !emp & o_ready;
        if (out_x) begin
            void'(mq.pop_front());
            lp0 = f.a0; lq0 = f.b0; lp1 = f.a1; lq1 = f.b1;
            if (f.last) pairs++;
        end
        if (in_x) begin
            mq.push_back('{a0: ia[3:0], b0: ib[3:0], a1: ia[7:4], b1: ib[7:4], last: 1'b0, perr: cur_bad});
            mq.push_back('{a0: ia[7:4], b0: ib[7:4], a1: ia[3:0], b1: ib[3:0], last: 1'b1, perr: cur_bad});
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1; dv = 1'b1; ia = 8'h5A; ib = 8'hC3; o_ready = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0; dv = 1'b0;
        mq.delete();
        lp0 = '0; lq0 = '0; lp1 = '0; lq1 = '0;
        pairs = 0;
        #1;
        chk("rst_ena",   32'(ena0 | ena1), 32'(0));
        chk("rst_cnt",   32'(cnt0),        32'(0));
        chk("rst_cnt1",  32'(cnt1),        32'(0));
        chk("rst_ir",    32'(ir0 & ir1),   32'(1));
        chk("rst_last",  32'(last0 | last1), 32'(0));
        chk("rst_param", 32'({p0, q0, p1, q1}), 32'(0));
`ifdef COMP_SPLIT_PARITY_EN
        chk("rst_par",   32'(par0 | par1), 32'(0));
`endif
    endtask

    vec_t       tv[14];
    logic [1:0] cexp[5];

    initial begin
        int acc, run, maxrun;
        int unsigned c0;
        rst = 1'b1; dv = 1'b0; o_ready = 1'b0; ia = '0; ib = '0; cur_bad = 1'b0;
`ifdef COMP_SPLIT_PARITY_EN
        ipar = 1'b0;
`endif
        tv[0]  = '{1'b1, 8'hA5, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 16'd0};
        tv[1]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 4'h5, 4'hC, 4'hA, 4'h3, 16'd0};
        tv[2]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 4'hA, 4'h3, 4'h5, 4'hC, 16'd0};
        tv[3]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4'hA, 4'h3, 4'h5, 4'hC, 16'd1};
        tv[4]  = '{1'b1, 8'h7E, 8'h19, 1'b1, 1'b0, 1'b1, 1'b0, 4'hA, 4'h3, 4'h5, 4'hC, 16'd1};
        for (int i = 5; i < 10; i++)
            tv[i] = '{1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 4'hE, 4'h9, 4'h7, 4'h1, 16'd1};
        tv[10] = '{1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 4'hE, 4'h9, 4'h7, 4'h1, 16'd1};
        tv[11] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 4'h7, 4'h1, 4'hE, 4'h9, 16'd1};
        tv[12] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 4'h7, 4'h1, 4'hE, 4'h9, 16'd1};
        tv[13] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4'h7, 4'h1, 4'hE, 4'h9, 16'd2};
        cexp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        do_reset(3);

        for (int i = 0; i < 14; i++) begin
            drive(tv[i].dv, tv[i].a, tv[i].b, tv[i].r, 1'b0);
            chk($sformatf("v%0d_ena", i),  32'(ena0),  32'(tv[i].ena));
            chk($sformatf("v%0d_ir", i),   32'(ir0),   32'(tv[i].ir));
            chk($sformatf("v%0d_last", i), 32'(last0), 32'(tv[i].last));
            chk($sformatf("v%0d_p0", i),   32'(p0),    32'(tv[i].p0));
            chk($sformatf("v%0d_q0", i),   32'(q0),    32'(tv[i].q0));
            chk($sformatf("v%0d_p1", i),   32'(p1),    32'(tv[i].p1));
            chk($sformatf("v%0d_q1", i),   32'(q1),    32'(tv[i].q1));
            chk($sformatf("v%0d_cnt", i),  32'(cnt0),  32'(tv[i].cnt));
            mcheck();
        end

        acc = 0; run = 0; maxrun = 0; c0 = pairs;
        for (int i = 0; i < 12; i++) begin
            drive(acc < 4, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
            run = ena0 ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
            if (dv && ir0) acc++;
            mcheck();
        end
        chk("b2b_run",   32'(maxrun), 32'(8));
        chk("b2b_count", 32'(cnt0),   32'(c0 + 4));

        do_reset(1);
        drive(1'b1, 8'hA5, 8'h3C, 1'b1, 1'b0); mcheck();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("msb_first_beat", 32'({p1, q1}), 32'(8'hA3));
        mcheck();
        do_reset(1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
            chk("no_beat_after_rst", 32'({ena1, p1}), 32'(0));
            mcheck();
        end

        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 8'($urandom), 8'($urandom), 1'b1, 1'b0); mcheck();
            repeat (3) begin
                drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b0); mcheck();
            end
            chk($sformatf("cntw2_%0d", k), 32'(cnt1), 32'(cexp[k]));
        end

`ifdef COMP_SPLIT_PARITY_EN
        drive(1'b1, 8'hA5, 8'h3C, 1'b1, 1'b1); mcheck();
        drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        chk("par_inv_b0", 32'({par0, par1}), 32'(2'b11));
        mcheck();
        drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        chk("par_inv_b1", 32'({par0, par1}), 32'(2'b11));
        mcheck();
`endif

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 63) == 0) do_reset(1);
            else begin
                drive($urandom_range(0, 1) == 1, 8'($urandom), 8'($urandom),
                      $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
                mcheck();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
